// File: rtl/hazard_if.sv
// Signal bundle between the 5-stage pipeline and its hazard controller:
// register-field and control inputs in, stall/flush/forward controls and counters out.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             LoadE;
  logic             PCSrcE;
  logic             MulDivE;
  logic             MdDone;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MdStart;
  logic             MdTimeout;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivE, MdDone,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, MdStart, MdTimeout, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivE, MdDone,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, MdStart, MdTimeout, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, EX forwarding selects, branch flushes,
// multi-cycle mul/div sequencing with timeout, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  localparam int            TW   = $clog2(MD_TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [TW-1:0]    md_cnt_r;
  logic             md_timeout_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic             lw_stall_s;
  logic             stall_fd_s;
  logic             stall_e_s;
  logic             flush_d_s;
  logic             flush_e_s;
  logic             flush_m_s;
  logic             md_start_s;
  logic             md_to_s;

  // MEM result has priority over WB since it is the younger producer
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rw_m,
                                         input logic [4:0] rd_m, input logic rw_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + CNT_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign lw_stall_s = hz.LoadE && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Next-state and raw control decode; reset forcing is applied at the outputs
  always_comb begin
    state_nxt_s = state_r;
    stall_fd_s  = 1'b0;
    stall_e_s   = 1'b0;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    flush_m_s   = 1'b0;
    md_start_s  = 1'b0;
    md_to_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (hz.MulDivE) begin
          md_start_s  = 1'b1;
          stall_fd_s  = 1'b1;
          stall_e_s   = 1'b1;
          flush_m_s   = 1'b1;
          state_nxt_s = MD_BUSY;
        end else begin
          stall_fd_s  = lw_stall_s;
          flush_e_s   = lw_stall_s || hz.PCSrcE;
          flush_d_s   = hz.PCSrcE;
          state_nxt_s = IDLE;
        end
      end
      MD_BUSY: begin
        stall_fd_s = 1'b1;
        stall_e_s  = 1'b1;
        flush_m_s  = 1'b1;
        // a done pulse in the last allowed cycle still counts as success
        if (hz.MdDone) begin
          state_nxt_s = IDLE;
        end else if (md_cnt_r == TMAX) begin
          md_to_s     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MD_BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, busy-cycle counter, sticky timeout flag and performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      md_cnt_r     <= '0;
      md_timeout_r <= 1'b0;
      stall_cnt_r  <= '0;
      flush_cnt_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      md_timeout_r <= md_timeout_r | md_to_s;
      stall_cnt_r  <= sat_inc(stall_cnt_r, stall_fd_s);
      flush_cnt_r  <= sat_inc(flush_cnt_r, flush_d_s);
      if (state_r == MD_BUSY) begin
        md_cnt_r <= md_cnt_r + TW'(1);
      end else begin
        md_cnt_r <= '0;
      end
    end
  end

  assign hz.StallF    = reset & stall_fd_s;
  assign hz.StallD    = reset & stall_fd_s;
  assign hz.StallE    = reset & stall_e_s;
  assign hz.FlushD    = ~reset | flush_d_s;
  assign hz.FlushE    = ~reset | flush_e_s;
  assign hz.FlushM    = ~reset | flush_m_s;
  assign hz.MdStart   = reset & md_start_s;
  assign hz.ForwardAE = reset ? fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW) : 2'b00;
  assign hz.ForwardBE = reset ? fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW) : 2'b00;
  assign hz.MdTimeout = md_timeout_r;
  assign hz.StallCnt  = stall_cnt_r;
  assign hz.FlushCnt  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// all compared every cycle against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int MDT  = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  hazard_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  // reference model state
  bit m_busy;
  int m_n;
  bit m_to;
  int m_sc;
  int m_fc;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int fwd(input int rs);
    if (hz.RegWriteM && hz.RdM != 0 && int'(hz.RdM) == rs) return 2;
    if (hz.RegWriteW && hz.RdW != 0 && int'(hz.RdW) == rs) return 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0;
    hz.PCSrcE = 1'b0; hz.MulDivE = 1'b0; hz.MdDone = 1'b0;
  endtask

  // Called just after a falling edge with inputs set: check, clock, advance the model.
  task automatic cycle();
    int sf, se, fd, fe, fm, st, fa, fb;
    bit lw;
    #1;
    lw = hz.LoadE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    if (!reset) begin
      sf = 0; se = 0; fd = 1; fe = 1; fm = 1; st = 0; fa = 0; fb = 0;
    end else begin
      fa = fwd(int'(hz.Rs1E));
      fb = fwd(int'(hz.Rs2E));
      if (m_busy) begin
        sf = 1; se = 1; fd = 0; fe = 0; fm = 1; st = 0;
      end else if (hz.MulDivE) begin
        sf = 1; se = 1; fd = 0; fe = 0; fm = 1; st = 1;
      end else begin
        sf = lw; se = 0; fd = hz.PCSrcE; fe = lw || hz.PCSrcE; fm = 0; st = 0;
      end
    end
    chk("StallF", hz.StallF, sf);
    chk("StallD", hz.StallD, sf);
    chk("StallE", hz.StallE, se);
    chk("FlushD", hz.FlushD, fd);
    chk("FlushE", hz.FlushE, fe);
    chk("FlushM", hz.FlushM, fm);
    chk("MdStart", hz.MdStart, st);
    chk("ForwardAE", hz.ForwardAE, fa);
    chk("ForwardBE", hz.ForwardBE, fb);
    chk("MdTimeout", hz.MdTimeout, m_to);
    chk("StallCnt", hz.StallCnt, m_sc);
    chk("FlushCnt", hz.FlushCnt, m_fc);
    @(posedge clk);
    if (!reset) begin
      m_busy = 0; m_n = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_sc = (m_sc + sf > CMAX) ? CMAX : m_sc + sf;
      m_fc = (m_fc + fd > CMAX) ? CMAX : m_fc + fd;
      if (m_busy) begin
        if (hz.MdDone) m_busy = 0;
        else if (m_n == MDT - 1) begin m_to = 1; m_busy = 0; end
        else m_n++;
      end else if (hz.MulDivE) begin
        m_busy = 1; m_n = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    clear_inputs();
    m_busy = 0; m_n = 0; m_to = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    // reset state, with forwarding inputs that would otherwise select MEM
    hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd5; hz.PCSrcE = 1'b1;
    cycles(2);
    reset = 1'b1;
    clear_inputs();
    cycle();

    // forwarding: MEM wins over WB, then WB when RdM is x0
    hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd0;
    cycle();
    hz.RdM = 5'd0;
    cycle();
    hz.Rs2E = 5'd5; hz.RegWriteW = 1'b0;
    cycle();
    clear_inputs();

    // load-use for one cycle, then x0 destination gives no stall
    hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    cycle();
    clear_inputs();
    cycle();
    hz.LoadE = 1'b1; hz.RdE = 5'd0;
    cycle();
    clear_inputs();
    chk("lw_stall_cnt", hz.StallCnt, 1);

    // branch flush, then branch together with load-use
    hz.PCSrcE = 1'b1;
    cycle();
    hz.LoadE = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
    cycle();
    clear_inputs();
    chk("branch_flush_cnt", hz.FlushCnt, 2);

    // mul/div finishing 4 cycles after start; stray branch and done pulses ignored
    hz.MdDone = 1'b1;
    cycle();
    hz.MdDone = 1'b0; hz.MulDivE = 1'b1;
    cycle();
    hz.PCSrcE = 1'b1;
    cycles(3);
    hz.PCSrcE = 1'b0; hz.MdDone = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    chk("md_no_timeout", hz.MdTimeout, 0);

    // timeout after MDT busy cycles; flag is sticky
    hz.MulDivE = 1'b1;
    cycle();
    hz.MulDivE = 1'b0;
    cycles(MDT + 2);
    chk("md_timeout_set", hz.MdTimeout, 1);
    cycles(2);
    chk("md_timeout_sticky", hz.MdTimeout, 1);

    // reset clears; done in the timeout cycle keeps the flag clear
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    hz.MulDivE = 1'b1;
    cycle();
    hz.MulDivE = 1'b0;
    cycles(MDT - 1);
    hz.MdDone = 1'b1;
    cycle();
    hz.MdDone = 1'b0;
    cycle();
    chk("done_at_timeout", hz.MdTimeout, 0);

    // reset in the middle of MD_BUSY
    hz.MulDivE = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    hz.MulDivE = 1'b0;
    cycle();
    chk("rst_mid_cnt", hz.StallCnt, 0);

    // stall counter saturation via two timeouts
    for (int k = 0; k < 2; k++) begin
      hz.MulDivE = 1'b1;
      cycle();
      hz.MulDivE = 1'b0;
      cycles(MDT);
    end
    cycle();
    chk("stall_cnt_sat", hz.StallCnt, CMAX);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE = 5'($urandom_range(0, 3)); hz.RdM = 5'($urandom_range(0, 3));
      hz.RdW = 5'($urandom_range(0, 3));
      hz.RegWriteM = 1'($urandom_range(0, 1)); hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.LoadE = 1'($urandom_range(0, 1));
      hz.PCSrcE = ($urandom_range(0, 3) == 0);
      hz.MulDivE = ($urandom_range(0, 7) == 0);
      hz.MdDone = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 49) != 0);
      cycle();
    end
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
